cp_insert: RTL and testbench
============================

# cp_insert

Cyclic-prefix insertion stage of the transmit chain. It sits between the IFFT output and the preamble/output stage. It buffers each time-domain OFDM symbol of N_FFT samples and re-emits it as the last N_CP samples followed by the full symbol, so each symbol goes out as N_FFT+N_CP samples. Two symbol banks work in ping-pong, so the next symbol is written while the current one is read out. Both sides use the pipeline's Wishbone-style streaming handshake.

## Interface
- N_FFT, 2048, symbol length in samples; must be a power of two, ≥ 4.
- N_CP, 512, prefix length; must satisfy 1 ≤ N_CP ≤ N_FFT-1.
- DW, 32, sample width: {I[31:16], Q[15:0]}, passed through untouched.
- CLK_I  in  1  single clock; all logic on its rising edge.
- RST_I  in  1  synchronous, active-high reset.
- DAT_I  in  DW  input sample from the IFFT.
- CYC_I  in  1  input burst active; a falling edge ends the burst.
- WE_I  in  1  write qualifier.
- STB_I  in  1  input sample valid.
- ACK_O  out  1  input sample accepted this cycle (combinational).
- DAT_O  out  DW  output sample (registered).
- CYC_O  out  1  output burst active (registered).
- STB_O  out  1  output sample valid (registered).
- WE_O  out  1  equals STB_O.
- ACK_I  in  1  downstream accepts DAT_O; a transfer occurs when STB_O & ACK_I.

## Operation
- ena = CYC_I & STB_I & WE_I.
- ACK_O = ena & (current write bank is EMPTY).
- Each ACKed sample is written to wr_bank at address wr_ptr, then wr_ptr increments.
- When wr_ptr = N_FFT-1 is ACKed: the bank becomes FULL, wr_ptr goes to 0, and wr_bank toggles.
- Each bank has a 1-bit state, EMPTY or FULL.
- Read FSM states: IDLE, CP, BODY.
  - IDLE → CP when rd_bank is FULL; rd_ptr = N_FFT-N_CP.
  - CP: read rd_ptr up to N_FFT-1, then go to BODY with rd_ptr = 0.
  - BODY: read 0 to N_FFT-1. After the last read, mark rd_bank EMPTY and toggle rd_bank. Go directly to CP if the new rd_bank is FULL, otherwise go to IDLE.
- A read address advances only when the output register is free or is being drained in the same cycle (STB_O & ACK_I). The output never drops or duplicates a sample under backpressure.
- CYC_O:
  - Set when a bank first becomes FULL while CYC_O = 0.
  - Cleared when CYC_I = 0, both banks are EMPTY, the FSM is IDLE, and no sample is held in the output pipeline.
- CYC_I falling with wr_ptr ≠ 0: the partial symbol is discarded (wr_ptr → 0). FULL banks still drain completely.
- Simultaneous events:
  - A write completing bank A in the same cycle the reader frees bank B: both take effect, with no bubble.
  - A write may target the bank being freed in the same cycle only from the next cycle on.

## Timing
- Reset values: ACK_O 0, DAT_O 0, CYC_O 0, STB_O 0, WE_O 0. Reset also sets both banks EMPTY, FSM to IDLE, and all pointers and bank selects to 0.
- Reset takes effect mid-operation: all buffered data is discarded.
- RAM read latency is 1 cycle and the output register adds 1 more. The first STB_O comes 3 cycles after the cycle in which the last input sample of a symbol is ACKed. CYC_O rises 1 cycle before that first STB_O.
- With ACK_I held at 1, output throughput is 1 sample/cycle with no gaps between consecutive FULL symbols.
- Input throughput is bounded: at most 2·N_FFT samples are ACKed before the first output drain.
- Output stall: STB_O & ~ACK_I holds DAT_O and STB_O stable.

## Structure
- Package cp_pkg:
  - default N_FFT, N_CP, DW;
  - AW = $clog2(N_FFT);
  - enum for the read-FSM states {IDLE, CP, BODY};
  - sample typedef.
- Sub-module cp_sym_ram: simple dual-port RAM, depth 2·N_FFT, width DW, one write port and one registered read port. Address is {bank, ptr}.

## Test plan
- N_FFT=8, N_CP=2, ACK_I=1, single symbol 0..7 → DAT_O = 6,7,0,1,2,3,4,5,6,7 on consecutive cycles. CYC_O then falls after CYC_I drops.
- Three back-to-back symbols 0..7, 8..15, 16..23 with ACK_I=1 → 30 contiguous outputs 6,7,0..7,14,15,8..15,22,23,16..23. ACK_O is low while both banks are FULL.
- Random ACK_I (50%) on the same three symbols → identical output sequence, no drop or duplication, DAT_O stable while stalled.
- CYC_I drops after 5 samples of a symbol → no STB_O, CYC_O stays 0; the next burst's symbol comes out cleanly.
- RST_I pulsed mid-BODY → all outputs 0 on the next cycle. A fresh symbol afterwards is emitted correctly.
- Default parameters, one ramp symbol → exactly 2560 outputs; the first output equals input sample 1536.

Source files
------------

// File: rtl/cp_pkg.sv
// Shared definitions for the cyclic-prefix insertion stage: default geometry,
// read-FSM state encoding and the sample type.
package cp_pkg;

  localparam int DEF_N_FFT = 2048;
  localparam int DEF_N_CP  = 512;
  localparam int DEF_DW    = 32;
  localparam int DEF_AW    = $clog2(DEF_N_FFT);

  typedef enum logic [1:0] {
    IDLE,
    CP,
    BODY
  } rd_state_e;

  // {I[31:16], Q[15:0]}, carried through untouched
  typedef logic [DEF_DW-1:0] sample_t;

endpackage

// File: rtl/cp_sym_ram.sv
// Simple dual-port symbol store: one write port, one registered read port.
// The address MSB selects the ping-pong bank.
module cp_sym_ram #(
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  // NOTE: the array and its read register carry no reset so they map onto block RAM;
  // the bank FULL/EMPTY flags in the parent decide what is valid.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/cp_insert.sv
// Cyclic-prefix insertion: buffers N_FFT-sample symbols in two ping-pong banks
// and replays each as its last N_CP samples followed by the whole symbol.
module cp_insert
  import cp_pkg::*;
#(
  parameter int N_FFT = DEF_N_FFT,
  parameter int N_CP  = DEF_N_CP,
  parameter int DW    = DEF_DW
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [DW-1:0] DAT_I,
  input  logic          CYC_I,
  input  logic          WE_I,
  input  logic          STB_I,
  output logic          ACK_O,
  output logic [DW-1:0] DAT_O,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  input  logic          ACK_I
);

  localparam int            AW       = $clog2(N_FFT);
  localparam logic [AW-1:0] PTR_LAST = AW'(N_FFT - 1);
  localparam logic [AW-1:0] CP_START = AW'(N_FFT - N_CP);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_cur;
  logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  rd_state_e     state_q, state_d;
  logic          rd_vld_q, rd_vld_d, stb_q, stb_d, cyc_q, cyc_d;
  logic [DW-1:0] dat_q, dat_d, ram_rdata;
  logic          ack, wr_done, out_free, rd_fire, rd_free, next_full;

  assign ack     = CYC_I & STB_I & WE_I & ~full_q[wr_bank_q] & ~RST_I;
  assign wr_done = ack & (wr_ptr_q == PTR_LAST);

  cp_sym_ram #(.DW(DW), .AW(AW + 1)) u_ram (
    .clk_i   (CLK_I),
    .we_i    (ack),
    .waddr_i ({wr_bank_q, wr_ptr_q}),
    .wdata_i (DAT_I),
    .re_i    (rd_fire),
    .raddr_i ({rd_bank_q, rd_ptr_cur}),
    .rdata_o (ram_rdata)
  );

  // Read FSM: state register
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // Read FSM: output logic. IDLE issues the first prefix read itself so the
  // first sample leaves three cycles after the symbol completes.
  always_comb begin
    out_free   = ~stb_q | ACK_I;
    rd_ptr_cur = (state_q == IDLE) ? CP_START : rd_ptr_q;
    rd_fire    = out_free & full_q[rd_bank_q];
  end

  // Bank completing this very cycle counts as FULL, so the hand-over has no bubble
  assign next_full = full_q[~rd_bank_q] | (wr_done & (wr_bank_q != rd_bank_q));

  // Read FSM: next-state logic
  // NOTE: every output of an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    rd_bank_d = rd_bank_q;
    rd_free   = 1'b0;
    if (rd_fire) begin
      if (state_q != BODY) begin
        if (rd_ptr_cur == PTR_LAST) begin
          state_d  = BODY;
          rd_ptr_d = '0;
        end else begin
          state_d  = CP;
          rd_ptr_d = rd_ptr_cur + 1'b1;
        end
      end else if (rd_ptr_q == PTR_LAST) begin
        rd_free   = 1'b1;
        rd_bank_d = ~rd_bank_q;
        rd_ptr_d  = CP_START;
        state_d   = next_full ? CP : IDLE;
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  // Write side, bank flags, two-stage output pipeline and burst framing
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    if (!CYC_I) begin
      wr_ptr_d = '0;
    end else if (ack) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_done) wr_bank_d = ~wr_bank_q;
    end

    full_d = full_q;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
    if (rd_free) full_d[rd_bank_q] = 1'b0;

    rd_vld_d = rd_fire | (rd_vld_q & ~out_free);
    stb_d    = out_free ? rd_vld_q : stb_q;
    dat_d    = (out_free & rd_vld_q) ? ram_rdata : dat_q;

    cyc_d = cyc_q;
    if (!cyc_q && (full_q != 2'b00)) begin
      cyc_d = 1'b1;
    end else if (!CYC_I && (full_q == 2'b00) && (state_q == IDLE) && !rd_vld_q && !stb_q) begin
      cyc_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wr_ptr_q  <= '0;
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
      rd_vld_q  <= 1'b0;
      stb_q     <= 1'b0;
      dat_q     <= '0;
      cyc_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      rd_vld_q  <= rd_vld_d;
      stb_q     <= stb_d;
      dat_q     <= dat_d;
      cyc_q     <= cyc_d;
    end
  end

  assign ACK_O = ack;
  assign DAT_O = dat_q;
  assign CYC_O = cyc_q;
  assign STB_O = stb_q;
  assign WE_O  = stb_q;

endmodule

// File: tb/tb_cp_insert.sv
// Directed bench for cp_insert: table of symbol bursts on an N_FFT=8/N_CP=2
// instance, hand sequences for abort/reset, and a default-size ramp symbol.
module tb_cp_insert;
  import cp_pkg::*;

  localparam int NF = 8;
  localparam int NC = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] dat_i, dat_o;
  logic          cyc_i, we_i, stb_i, ack_o, cyc_o, stb_o, we_o, ack_i;
  sample_t       b_dat_i, b_dat_o;
  logic          b_cyc_i, b_we_i, b_stb_i, b_ack_o, b_cyc_o, b_stb_o, b_we_o, b_ack_i;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int          cycle = 0;

  cp_insert #(.N_FFT(NF), .N_CP(NC), .DW(DW)) dut (
    .CLK_I(clk), .RST_I(rst), .DAT_I(dat_i), .CYC_I(cyc_i), .WE_I(we_i), .STB_I(stb_i),
    .ACK_O(ack_o), .DAT_O(dat_o), .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o), .ACK_I(ack_i)
  );

  cp_insert dut_big (
    .CLK_I(clk), .RST_I(rst), .DAT_I(b_dat_i), .CYC_I(b_cyc_i), .WE_I(b_we_i), .STB_I(b_stb_i),
    .ACK_O(b_ack_o), .DAT_O(b_dat_o), .CYC_O(b_cyc_o), .STB_O(b_stb_o), .WE_O(b_we_o), .ACK_I(b_ack_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string name;
    int    base;
    int    nsym;
    bit    rand_ack;
    int    exp_outs;
    int    exp_first;
    int    exp_last;
    int    exp_span;   // -1: not checked
    int    exp_wait;   // -1: not checked
  } vec_t;

  // Writes nsym symbols while a concurrent monitor drains the output.
  task automatic run_case(input vec_t v);
    int exp_q[$];
    int rx = 0, first_val = -1, last_val = -1, first_stb = -1, last_stb = -1;
    int first_cyc = -1, last_ack0 = -1, waits = 0;
    bit wr_done = 1'b0;
    for (int s = 0; s < v.nsym; s++)
      for (int k = 0; k < NC + NF; k++)
        exp_q.push_back(v.base + s * NF + ((k < NC) ? (NF - NC + k) : (k - NC)));
    ack_i = 1'b1;
    fork
      begin
        bit abort;
        abort = 1'b0;
        @(negedge clk);
        cyc_i = 1'b1;
        we_i  = 1'b1;
        for (int s = 0; s < v.nsym && !abort; s++) begin
          for (int k = 0; k < NF && !abort; k++) begin
            int budget;
            budget = 0;
            dat_i  = DW'(v.base + s * NF + k);
            stb_i  = 1'b1;
            #1;
            while (!ack_o && budget < 200) begin
              waits++;
              budget++;
              @(negedge clk);
              #1;
            end
            if (!ack_o) begin
              abort = 1'b1;
              check({v.name, "/ack_timeout"}, 64'(ack_o), 64'(1));
            end else begin
              if (s == 0 && k == NF - 1) last_ack0 = cycle;
              @(negedge clk);
            end
          end
        end
        stb_i   = 1'b0;
        cyc_i   = 1'b0;
        we_i    = 1'b0;
        wr_done = 1'b1;
      end
      begin
        bit            prev_stall;
        logic [DW-1:0] prev_dat;
        prev_stall = 1'b0;
        prev_dat   = '0;
        for (int n = 0; n < 3000; n++) begin
          @(negedge clk);
          if (prev_stall) check({v.name, "/stall_hold"}, 64'({stb_o, dat_o}), 64'({1'b1, prev_dat}));
          if (cyc_o && first_cyc < 0) first_cyc = cycle;
          ack_i = v.rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
          if (stb_o && ack_i) begin
            if (rx == 0) begin
              first_val = int'(dat_o);
              first_stb = cycle;
            end
            last_val = int'(dat_o);
            last_stb = cycle;
            rx++;
            check({v.name, "/we_o"}, 64'(we_o), 64'(1));
            if (exp_q.size() > 0) check({v.name, "/sample"}, 64'(dat_o), 64'(exp_q.pop_front()));
          end
          prev_stall = stb_o & ~ack_i;
          prev_dat   = dat_o;
          if (wr_done && !cyc_o && !stb_o && rx > 0) break;
        end
        ack_i = 1'b1;
      end
    join
    check({v.name, "/count"}, 64'(rx), 64'(v.exp_outs));
    check({v.name, "/first"}, 64'(first_val), 64'(v.exp_first));
    check({v.name, "/last"}, 64'(last_val), 64'(v.exp_last));
    check({v.name, "/latency"}, 64'(first_stb - last_ack0), 64'(3));
    check({v.name, "/cyc_lead"}, 64'(first_stb - first_cyc), 64'(1));
    check({v.name, "/cyc_fall"}, 64'(cyc_o), 64'(0));
    if (v.exp_span >= 0) check({v.name, "/span"}, 64'(last_stb - first_stb + 1), 64'(v.exp_span));
    if (v.exp_wait >= 0) check({v.name, "/ack_wait"}, 64'(waits), 64'(v.exp_wait));
  endtask

  initial begin
    vec_t vecs[4];
    vec_t v;
    int   seen, n, bad, cnt, mism, first;

    vecs[0] = '{"single",    0,        1, 1'b0, 10, 6,        7,        10, 0};
    vecs[1] = '{"three",     0,        3, 1'b0, 30, 6,        23,       30, 2};
    vecs[2] = '{"three_rnd", 0,        3, 1'b1, 30, 6,        23,       -1, -1};
    vecs[3] = '{"two_rnd",   'h1000,   2, 1'b1, 20, 'h1006,   'h100F,   -1, -1};

    rst = 1'b1;
    {dat_i, cyc_i, we_i, stb_i} = '0;
    ack_i = 1'b1;
    {b_dat_i, b_cyc_i, b_we_i, b_stb_i} = '0;
    b_ack_i = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outs", 64'({dat_o, cyc_o, stb_o, we_o, ack_o}), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_outs", 64'({dat_o, cyc_o, stb_o, we_o, ack_o}), 64'(0));

    for (int i = 0; i < 4; i++) run_case(vecs[i]);

    // Burst aborted after 5 samples: nothing may come out
    @(negedge clk);
    cyc_i = 1'b1;
    we_i  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      dat_i = DW'(500 + k);
      stb_i = 1'b1;
      #1;
      check("partial_ack", 64'(ack_o), 64'(1));
      @(negedge clk);
    end
    {cyc_i, we_i, stb_i} = '0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen |= int'(stb_o | cyc_o);
    end
    check("partial_quiet", 64'(seen), 64'(0));
    v = '{"after_abort", 'h40, 1, 1'b0, 10, 'h46, 'h47, 10, 0};
    run_case(v);

    // Reset pulsed while the body of a symbol is streaming
    @(negedge clk);
    cyc_i = 1'b1;
    we_i  = 1'b1;
    for (int k = 0; k < NF; k++) begin
      dat_i = DW'('h70 + k);
      stb_i = 1'b1;
      #1;
      check("rst_seq_ack", 64'(ack_o), 64'(1));
      @(negedge clk);
    end
    {cyc_i, we_i, stb_i} = '0;
    n = 0;
    while (!stb_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_seq_start", 64'(stb_o), 64'(1));
    repeat (4) @(negedge clk);
    check("rst_pre_dat", 64'(dat_o), 64'('h72));
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", 64'({dat_o, cyc_o, stb_o, we_o, ack_o}), 64'(0));
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen |= int'(stb_o | cyc_o);
    end
    check("rst_discard", 64'(seen), 64'(0));
    v = '{"after_reset", 'h90, 1, 1'b0, 10, 'h96, 'h97, 10, 0};
    run_case(v);

    // Default geometry, one ramp symbol
    @(negedge clk);
    b_cyc_i = 1'b1;
    b_we_i  = 1'b1;
    bad     = 0;
    for (int k = 0; k < DEF_N_FFT; k++) begin
      b_dat_i = sample_t'(k);
      b_stb_i = 1'b1;
      #1;
      if (!b_ack_o) bad++;
      @(negedge clk);
    end
    {b_cyc_i, b_we_i, b_stb_i} = '0;
    check("big_ack_gaps", 64'(bad), 64'(0));
    cnt   = 0;
    mism  = 0;
    first = -1;
    for (int k = 0; k < 6000; k++) begin
      @(negedge clk);
      if (b_stb_o) begin
        if (cnt == 0) first = int'(b_dat_o);
        if (b_dat_o !== sample_t'((cnt < DEF_N_CP) ? (DEF_N_FFT - DEF_N_CP + cnt) : (cnt - DEF_N_CP)))
          mism++;
        if (b_we_o !== 1'b1) mism++;
        cnt++;
      end
      if (cnt > 0 && !b_cyc_o) break;
    end
    check("big_count", 64'(cnt), 64'(2560));
    check("big_first", 64'(first), 64'(1536));
    check("big_sequence", 64'(mism), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
